nec_uart_fmt: RTL and testbench
===============================

# nec_uart_fmt

Downstream of the NEC IR decoder and upstream of the UART transmitter. Converts decoded-command and repeat events into ASCII text lines and hands them to the transmitter one byte at a time over a valid/ready handshake. A small FIFO absorbs bursts of events while a line is still being sent. Overflows are flagged and counted.

## Interface
- FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16
- HEX_UPPER, 1, 1 = hex digits 'A'-'F' (0x41-0x46); 0 = 'a'-'f' (0x61-0x66)

- sys_clk  in  1  system clock; sole clock of the block
- sys_rst  in  1  synchronous, active-high reset
- data_in  in  8  decoded command byte; valid while data_in_en is high
- data_in_en  in  1  command-valid level from the decoder; may stay high for many sys_clk cycles
- repeat_in_en  in  1  repeat-code level from the decoder; may stay high for many cycles
- tx_data  out  8  ASCII byte to the transmitter
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  transmitter accepts tx_data this cycle
- overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full
- drop_cnt  out  8  count of dropped events; saturates at 255

## Operation
- Edge detect:
  - Registers de_d and re_d hold the previous data_in_en and repeat_in_en.
  - An event fires only on a 0→1 transition.
  - de_d and re_d reset to 1, so an enable already high at reset release is not an event.
- Event capture (same cycle as the edge):
  - A data edge writes entry {rep=0, code=data_in}.
  - A repeat edge writes entry {rep=1, code=0}.
  - If both edges occur in the same cycle, only the data entry is written. The repeat is discarded and is not counted as a drop.
- FIFO:
  - Each entry is 9 bits.
  - Pointers are log2(FIFO_DEPTH)+1 bits, so full and empty are distinguished by the wrap bit.
  - A write when full is dropped:
    - overflow is pulsed.
    - drop_cnt increments unless it is already 255.
  - A write and a pop in the same cycle while full: both succeed and no drop occurs.
- Formatter FSM:
  - S_IDLE: if the FIFO is not empty, pop into cur, clear idx, and go to S_SEND. Otherwise stay.
  - S_SEND: tx_valid=1 and tx_data=char(cur, idx).
    - On tx_ready: if idx is the last character, go to S_IDLE; otherwise increment idx.
    - Without tx_ready: hold.
- Messages:
  - Data entry, 4 chars: hex(code[7:4]), hex(code[3:0]), 0x0D, 0x0A.
  - Repeat entry, 3 chars: 0x52 ('R'), 0x0D, 0x0A.
  - hex(n) is 0x30+n for n<10. For n≥10 it is 0x41+n−10 if HEX_UPPER=1, else 0x61+n−10.
- Handshake rules:
  - tx_data and tx_valid are registered outputs.
  - Once tx_valid is high, tx_data is stable and tx_valid stays high until tx_ready is sampled high.
  - tx_valid never drops between characters of one message.

## Timing
- Reset values:
  - tx_valid=0, tx_data=0x00, overflow=0, drop_cnt=0.
  - FIFO empty, FSM in S_IDLE, de_d=re_d=1.
- Latency:
  - Edge sampled in cycle N → entry written at end of N.
  - FSM pops in N+1 → tx_valid first high in N+2 with the first character.
- With tx_ready held at 1:
  - One character per cycle.
  - A data line occupies 4 consecutive tx_valid cycles; a repeat line occupies 3.
- Between messages: exactly one cycle with tx_valid=0 (the S_IDLE pop cycle), even if the FIFO is non-empty.
- Reset asserted mid-message: in the next cycle tx_valid=0 and the FIFO is emptied. The partial line is abandoned; no completion is sent.
- drop_cnt and overflow update in the same cycle as the rejected write edge becomes visible, i.e. registered at end of cycle N.

## Test plan
- Single command, ready tied high:
  - Stimulus: data_in=0xA5, data_in_en high for 50 cycles.
  - Response: exactly 0x41,0x35,0x0D,0x0A on 4 consecutive cycles, first tx_valid 2 cycles after the edge; no further bytes.
- Repeat event:
  - Stimulus: repeat_in_en rises.
  - Response: 0x52,0x0D,0x0A. A second rise after a low produces a second identical line.
- Back-pressure:
  - Stimulus: data 0x3C with tx_ready toggling 1,0,0,1,…
  - Response: tx_data holds each character while tx_ready=0. The sequence 0x33,0x43,0x0D,0x0A is unchanged.
  - With HEX_UPPER=0 the second character is 0x63.
- Overflow, with FIFO_DEPTH=4 and tx_ready=0:
  - Stimulus: 6 data edges with codes 0x01..0x06.
  - Response:
    - The first is popped into the formatter, so 4 more fit in the FIFO.
    - The 6th pulses overflow; drop_cnt=1.
    - After tx_ready=1, lines 01..05 are output in order.
  - Also check saturation: 260 drops → drop_cnt=255.
- Simultaneous and reset edges:
  - data and repeat rising in the same cycle → only the data line is output.
  - data_in_en held high across reset release → no output.
  - Reset pulsed during the 2nd character → tx_valid=0 the next cycle, no further output.

Source files
------------

// File: rtl/nec_uart_fmt.sv
// nec_uart_fmt: turns NEC decoder command/repeat events into ASCII lines for a UART.
//   Data event   -> two hex digits of the command byte, CR, LF
//   Repeat event -> 'R', CR, LF
// A small FIFO queues events while a line is still being sent. Events that
// arrive when the FIFO is full are dropped, flagged and counted.
//
// Ports:
//   sys_clk       system clock
//   sys_rst       synchronous active-high reset
//   data_in       decoded command byte, valid while data_in_en is high
//   data_in_en    command-valid level (the rising edge is the event)
//   repeat_in_en  repeat-code level (the rising edge is the event)
//   tx_data       ASCII byte to the transmitter (registered)
//   tx_valid      tx_data valid (registered, held until tx_ready)
//   tx_ready      transmitter accepts tx_data this cycle
//   overflow      one-cycle pulse when an event is dropped
//   drop_cnt      saturating count of dropped events
module nec_uart_fmt #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic        HEX_UPPER  = 1'b1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] data_in,
  input  logic       data_in_en,
  input  logic       repeat_in_en,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       overflow,
  output logic [7:0] drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic       r_de_d, r_re_d;
  logic       w_de_rise, w_re_rise, w_wr_req;
  logic [8:0] w_wr_entry;
  logic [8:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic       w_full, w_empty, w_pop, w_wr, w_drop;
  logic [8:0] w_head;

  state_t     r_state, w_state_nxt;
  logic [8:0] r_cur, w_cur_nxt;
  logic [1:0] r_idx, w_idx_nxt;
  logic [1:0] w_last;
  logic       r_tx_valid, w_tx_valid_nxt;
  logic [7:0] r_tx_data, w_tx_data_nxt;
  logic       r_overflow;
  logic [7:0] r_drop_cnt;

  function automatic logic [7:0] f_hex(input logic [3:0] n);
    if (n < 4'd10) f_hex = 8'h30 + {4'h0, n};
    else           f_hex = (HEX_UPPER ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  // Entry bit 8 = repeat flag, bits 7:0 = command code.
  function automatic logic [7:0] f_char(input logic [8:0] e, input logic [1:0] i);
    logic [7:0] c;
    c = '0;
    if (e[8]) begin
      case (i)
        2'd0:    c = 8'h52;
        2'd1:    c = 8'h0D;
        default: c = 8'h0A;
      endcase
    end else begin
      case (i)
        2'd0:    c = f_hex(e[7:4]);
        2'd1:    c = f_hex(e[3:0]);
        2'd2:    c = 8'h0D;
        default: c = 8'h0A;
      endcase
    end
    return c;
  endfunction

  // Edge detect; a data edge wins over a simultaneous repeat edge.
  assign w_de_rise  = data_in_en & ~r_de_d;
  assign w_re_rise  = repeat_in_en & ~r_re_d;
  assign w_wr_req   = w_de_rise | w_re_rise;
  assign w_wr_entry = w_de_rise ? {1'b0, data_in} : {1'b1, 8'h00};

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head  = r_mem[r_rptr[AW-1:0]];
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  // A pop in the same cycle frees the slot the write lands in.
  assign w_wr    = w_wr_req && (!w_full || w_pop);
  assign w_drop  = w_wr_req && w_full && !w_pop;

  always_ff @(posedge sys_clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= w_wr_entry;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_de_d     <= 1'b1;
      r_re_d     <= 1'b1;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_de_d     <= data_in_en;
      r_re_d     <= repeat_in_en;
      r_overflow <= w_drop;
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_cur      <= '0;
      r_idx      <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur      <= w_cur_nxt;
      r_idx      <= w_idx_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_data  <= w_tx_data_nxt;
    end
  end

  assign w_last = r_cur[8] ? 2'd2 : 2'd3;

  // Outputs are computed one cycle ahead so tx_valid/tx_data come straight from flops.
  always_comb begin
    w_state_nxt    = r_state;
    w_cur_nxt      = r_cur;
    w_idx_nxt      = r_idx;
    w_tx_valid_nxt = r_tx_valid;
    w_tx_data_nxt  = r_tx_data;
    case (r_state)
      S_IDLE: begin
        w_tx_valid_nxt = 1'b0;
        if (w_pop) begin
          w_cur_nxt      = w_head;
          w_idx_nxt      = '0;
          w_state_nxt    = S_SEND;
          w_tx_valid_nxt = 1'b1;
          w_tx_data_nxt  = f_char(w_head, 2'd0);
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          if (r_idx == w_last) begin
            w_state_nxt    = S_IDLE;
            w_tx_valid_nxt = 1'b0;
          end else begin
            w_idx_nxt     = r_idx + 2'd1;
            w_tx_data_nxt = f_char(r_cur, r_idx + 2'd1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_nec_uart_fmt.sv
module tb_nec_uart_fmt;

  localparam int unsigned DEPTH = 4;

  logic       sys_clk, sys_rst;
  logic [7:0] data_in;
  logic       data_in_en, repeat_in_en, tx_ready;
  logic [7:0] tx_data, tx_data2, drop_cnt, drop_cnt2;
  logic       tx_valid, tx_valid2, overflow, overflow2;

  nec_uart_fmt #(.FIFO_DEPTH(DEPTH), .HEX_UPPER(1'b1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .data_in(data_in), .data_in_en(data_in_en),
    .repeat_in_en(repeat_in_en), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .overflow(overflow), .drop_cnt(drop_cnt));

  nec_uart_fmt #(.FIFO_DEPTH(DEPTH), .HEX_UPPER(1'b0)) dut_lc (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .data_in(data_in), .data_in_en(data_in_en),
    .repeat_in_en(repeat_in_en), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready), .overflow(overflow2), .drop_cnt(drop_cnt2));

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  typedef struct {
    logic [7:0] u;
    logic [7:0] l;
  } exp_t;

  exp_t q_exp[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ready_mode = 0;  // 0 manual, 1 random, 2 pattern 1,0,0
  int   exp_drops = 0;

  function automatic logic [7:0] hexc(input int unsigned n, input logic up);
    if (n < 10) return 8'(32'h30 + n);
    if (up) return 8'(32'h41 + n - 10);
    return 8'(32'h61 + n - 10);
  endfunction

  task automatic push_line(input logic rep, input logic [7:0] code);
    exp_t e;
    if (rep) begin
      e.u = 8'h52; e.l = 8'h52; q_exp.push_back(e);
    end else begin
      e.u = hexc(code[7:4], 1'b1); e.l = hexc(code[7:4], 1'b0); q_exp.push_back(e);
      e.u = hexc(code[3:0], 1'b1); e.l = hexc(code[3:0], 1'b0); q_exp.push_back(e);
    end
    e.u = 8'h0D; e.l = 8'h0D; q_exp.push_back(e);
    e.u = 8'h0A; e.l = 8'h0A; q_exp.push_back(e);
  endtask

  function automatic int count_lines();
    int n = 0;
    foreach (q_exp[i]) if (q_exp[i].u == 8'h0A) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
    if (ready_mode == 1) tx_ready = ($urandom_range(0, 3) != 0);
    else if (ready_mode == 2) tx_ready = ((cyc % 3) == 0);
  endtask

  task automatic ev(input logic d, input logic r, input logic [7:0] code);
    data_in = code;
    data_in_en = d;
    repeat_in_en = r;
    if (d) push_line(1'b0, code);
    else if (r) push_line(1'b1, 8'h00);
    tick();
    data_in_en = 1'b0;
    repeat_in_en = 1'b0;
    tick();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q_exp.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_pending", q_exp.size(), 0);
    q_exp.delete();
    repeat (6) tick();
  endtask

  // Monitor: scores each accepted byte, handshake stability and the inter-line gap.
  exp_t       mon_e;
  logic       mon_hold = 1'b0;
  logic [7:0] mon_held;
  logic       mon_gap = 1'b0;

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      mon_hold = 1'b0;
      mon_gap  = 1'b0;
    end else begin
      if (mon_gap) begin
        checks++;
        if (tx_valid !== 1'b0) begin
          errors++;
          $display("FAIL line_gap: tx_valid=%b expected 0 after LF", tx_valid);
        end
        mon_gap = 1'b0;
      end
      if (mon_hold) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== mon_held) begin
          errors++;
          $display("FAIL hold: valid=%b data=%h expected valid=1 data=%h", tx_valid, tx_data, mon_held);
        end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        mon_hold = 1'b0;
        checks++;
        if (q_exp.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %h expected none", tx_data);
        end else begin
          mon_e = q_exp.pop_front();
          if (tx_data !== mon_e.u) begin
            errors++;
            $display("FAIL byte: got %h expected %h", tx_data, mon_e.u);
          end
          checks++;
          if (tx_valid2 !== 1'b1 || tx_data2 !== mon_e.l) begin
            errors++;
            $display("FAIL byte_lc: got valid=%b %h expected %h", tx_valid2, tx_data2, mon_e.l);
          end
          if (mon_e.u == 8'h0A) mon_gap = 1'b1;
        end
      end else if (tx_valid === 1'b1) begin
        mon_hold = 1'b1;
        mon_held = tx_data;
      end else begin
        mon_hold = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int kind;
    sys_rst = 1'b1;
    data_in = '0;
    data_in_en = 1'b0;
    repeat_in_en = 1'b0;
    tx_ready = 1'b1;
    repeat (3) tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    sys_rst = 1'b0;
    repeat (2) tick();

    // Single command, ready high, enable held for 50 cycles.
    data_in = 8'hA5;
    data_in_en = 1'b1;
    push_line(1'b0, 8'hA5);
    tick();
    chk("lat_edge_cycle", tx_valid, 0);
    tick();
    chk("lat_first_valid", {tx_valid, tx_data}, {1'b1, 8'h41});
    tick();
    chk("cons_char2", {tx_valid, tx_data}, {1'b1, 8'h35});
    tick();
    chk("cons_char3", {tx_valid, tx_data}, {1'b1, 8'h0D});
    tick();
    chk("cons_char4", {tx_valid, tx_data}, {1'b1, 8'h0A});
    tick();
    chk("after_line", tx_valid, 0);
    repeat (44) tick();
    data_in_en = 1'b0;
    drain(50);

    // Two repeat rises separated by a low.
    ev(1'b0, 1'b1, 8'h00);
    repeat (3) tick();
    ev(1'b0, 1'b1, 8'h00);
    drain(50);

    // Back-pressure with ready pattern 1,0,0.
    ready_mode = 2;
    ev(1'b1, 1'b0, 8'h3C);
    drain(100);
    ready_mode = 0;
    tx_ready = 1'b1;

    // Simultaneous data and repeat edges: data line only.
    ev(1'b1, 1'b1, 8'h9F);
    drain(50);

    // Randomized traffic, throttled so the FIFO cannot overflow.
    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      guard = 0;
      while (count_lines() > 2 && guard < 2000) begin
        tick();
        guard++;
      end
      chk("throttle_wait", (guard < 2000) ? 1 : 0, 1);
      repeat ($urandom_range(0, 4)) tick();
      kind = $urandom_range(0, 19);
      ev(kind < 17 ? (kind < 12) : 1'b1, kind >= 12, 8'($urandom));
    end
    drain(2000);
    chk("rand_no_drops", drop_cnt, exp_drops);
    ready_mode = 0;

    // Overflow: ready low, six edges; one in the formatter plus DEPTH in the FIFO.
    tx_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      data_in = 8'(i);
      data_in_en = 1'b1;
      if (i <= DEPTH + 1) push_line(1'b0, 8'(i));
      else exp_drops++;
      tick();
      chk("ovf_pulse", overflow, (i > DEPTH + 1) ? 1 : 0);
      chk("ovf_drop_cnt", drop_cnt, exp_drops);
      data_in_en = 1'b0;
      tick();
      chk("ovf_one_cycle", overflow, 0);
    end
    for (int i = 0; i < 260; i++) begin
      data_in = 8'hEE;
      data_in_en = 1'b1;
      exp_drops = (exp_drops < 255) ? exp_drops + 1 : 255;
      tick();
      chk("sat_pulse", overflow, 1);
      data_in_en = 1'b0;
      tick();
    end
    chk("sat_drop_cnt", drop_cnt, exp_drops);
    chk("sat_at_255", drop_cnt, 255);
    tx_ready = 1'b1;
    drain(200);

    // Enable held high across reset release: no event.
    sys_rst = 1'b1;
    data_in = 8'h77;
    data_in_en = 1'b1;
    exp_drops = 0;
    repeat (2) tick();
    chk("rst_clears_drop_cnt", drop_cnt, exp_drops);
    sys_rst = 1'b0;
    repeat (10) tick();
    chk("held_en_no_output", tx_valid, 0);
    data_in_en = 1'b0;
    repeat (3) tick();

    // Reset during the second character abandons the line.
    data_in = 8'hA5;
    data_in_en = 1'b1;
    push_line(1'b0, 8'hA5);
    tick();
    tick();
    tick();
    chk("mid_second_char", {tx_valid, tx_data}, {1'b1, 8'h35});
    sys_rst = 1'b1;
    q_exp.delete();
    tick();
    chk("mid_rst_valid", tx_valid, 0);
    chk("mid_rst_data", tx_data, 0);
    sys_rst = 1'b0;
    repeat (10) tick();
    chk("mid_rst_silent", tx_valid, 0);
    data_in_en = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
